// File: rtl/ram_arbiter.sv
// Arbiter between the 65C2402 CPU and one DMA requester for the single-port system RAM.
// The CPU owns the RAM by default; DMA is forced in after a bounded wait and runs bounded bursts.
module ram_arbiter #(
  parameter int WAIT_MAX  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] cpu_AB,
  input  logic [7:0]  cpu_DO,
  input  logic        cpu_WE,
  output logic [7:0]  cpu_DI,
  output logic        cpu_RDY,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [23:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        dma_rvalid,
  output logic        dma_err,
  output logic [23:0] ram_AB,
  output logic [7:0]  ram_DO,
  output logic        ram_WE,
  output logic        ram_RDY,
  input  logic [7:0]  ram_DI
);

  typedef enum logic {
    ST_CPU = 1'b0,
    ST_DMA = 1'b1
  } state_t;

  localparam logic [7:0]  WAIT_LAST  = 8'(WAIT_MAX - 1);
  localparam logic [7:0]  BURST_LAST = 8'(BURST_MAX - 1);
  localparam logic [23:0] VEC_BASE   = 24'hFFFFF0;

  state_t      state, state_nxt;
  state_t      prev_owner, prev_owner_nxt;
  logic [7:0]  wait_cnt, wait_nxt;
  logic [7:0]  burst_cnt, burst_nxt;
  logic [7:0]  cpu_di_hold, hold_nxt;
  logic        rvalid_q, rvalid_nxt;
  logic        err_q, err_nxt;
  logic        dma_slot;
  logic        vec_hit;

  assign vec_hit = (dma_addr >= VEC_BASE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_CPU;
      prev_owner  <= ST_CPU;
      wait_cnt    <= 8'd0;
      burst_cnt   <= 8'd0;
      cpu_di_hold <= 8'd0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      prev_owner  <= prev_owner_nxt;
      wait_cnt    <= wait_nxt;
      burst_cnt   <= burst_nxt;
      cpu_di_hold <= hold_nxt;
      rvalid_q    <= rvalid_nxt;
      err_q       <= err_nxt;
    end
  end

  // A DMA slot exists only in DMA state with a live request; a dropped request falls through to the CPU.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    burst_nxt = burst_cnt;
    dma_slot  = 1'b0;
    case (state)
      ST_CPU: begin
        if (dma_req) begin
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = ST_DMA;
            wait_nxt  = 8'd0;
            burst_nxt = 8'd0;
          end else begin
            wait_nxt = wait_cnt + 8'd1;
          end
        end else begin
          wait_nxt = 8'd0;
        end
      end
      ST_DMA: begin
        wait_nxt = 8'd0;
        if (dma_req) begin
          dma_slot  = reset_n;
          burst_nxt = burst_cnt + 8'd1;
          if (burst_cnt == BURST_LAST) begin
            state_nxt = ST_CPU;
          end
        end else begin
          state_nxt = ST_CPU;
        end
      end
      default: state_nxt = ST_CPU;
    endcase
  end

  always_comb begin
    cpu_RDY = reset_n && !dma_slot;
    dma_ack = dma_slot;
    ram_RDY = reset_n;
    ram_AB  = dma_slot ? dma_addr  : cpu_AB;
    ram_DO  = dma_slot ? dma_wdata : cpu_DO;
    if (!reset_n) begin
      ram_WE = 1'b0;
    end else if (dma_slot) begin
      ram_WE = dma_we && !vec_hit;
    end else begin
      ram_WE = cpu_WE;
    end
    // A stalled CPU keeps seeing its own last read value, never DMA read data.
    cpu_DI     = (prev_owner == ST_DMA) ? cpu_di_hold : ram_DI;
    dma_rdata  = ram_DI;
    dma_rvalid = rvalid_q;
    dma_err    = err_q;
  end

  always_comb begin
    prev_owner_nxt = dma_slot ? ST_DMA : ST_CPU;
    hold_nxt       = (prev_owner == ST_CPU) ? ram_DI : cpu_di_hold;
    rvalid_nxt     = dma_slot && !dma_we;
    err_nxt        = err_q || (dma_slot && dma_we && vec_hit);
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural single-port RAM
// (1-cycle registered read, read-only vector window at $FFFFF0-$FFFFFF).
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] cpu_AB;
  logic [7:0]  cpu_DO;
  logic        cpu_WE;
  logic [7:0]  cpu_DI;
  logic        cpu_RDY;
  logic        dma_req;
  logic        dma_we;
  logic [23:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;
  logic        dma_err;
  logic [23:0] ram_AB;
  logic [7:0]  ram_DO;
  logic        ram_WE;
  logic        ram_RDY;
  logic [7:0]  ram_DI = 8'h00;

  logic [7:0]  mem [0:1023];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.WAIT_MAX(4), .BURST_MAX(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_AB(cpu_AB), .cpu_DO(cpu_DO), .cpu_WE(cpu_WE), .cpu_DI(cpu_DI), .cpu_RDY(cpu_RDY),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_err(dma_err),
    .ram_AB(ram_AB), .ram_DO(ram_DO), .ram_WE(ram_WE), .ram_RDY(ram_RDY), .ram_DI(ram_DI)
  );

  // RAM model; its contents are (re)loaded whenever the RAM is held off by reset.
  always @(posedge clk) begin
    if (!ram_RDY) begin
      mem[10'h100] <= 8'h5A;
      mem[10'h200] <= 8'hA5;
      mem[10'h300] <= 8'h00;
      mem[10'h301] <= 8'h00;
      mem[10'h302] <= 8'h00;
      mem[10'h3F4] <= 8'hC3;
      ram_DI       <= 8'h00;
    end else begin
      if (ram_WE && (ram_AB < 24'hFFFFF0)) mem[ram_AB[9:0]] <= ram_DO;
      ram_DI <= mem[ram_AB[9:0]];
    end
  end

  task automatic applyStimulus(input logic rst_n, input logic [23:0] c_ab, input logic c_we,
                               input logic [7:0] c_do, input logic d_req, input logic d_we,
                               input logic [23:0] d_addr, input logic [7:0] d_wdata);
    @(posedge clk);
    #1;
    reset_n   = rst_n;
    cpu_AB    = c_ab;
    cpu_WE    = c_we;
    cpu_DO    = c_do;
    dma_req   = d_req;
    dma_we    = d_we;
    dma_addr  = d_addr;
    dma_wdata = d_wdata;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; cpu_AB = 24'h000100; cpu_WE = 1'b1; cpu_DO = 8'h77;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 24'h0; dma_wdata = 8'h0;

    $display("[TB] reset");
    applyStimulus(1'b0, 24'h000100, 1'b1, 8'h77, 1'b0, 1'b0, 24'h0, 8'h00);
    applyStimulus(1'b0, 24'h000100, 1'b1, 8'h77, 1'b0, 1'b0, 24'h0, 8'h00);
    checkOutput("rst_cpu_rdy", 32'(cpu_RDY), 32'd0);
    checkOutput("rst_dma_ack", 32'(dma_ack), 32'd0);
    checkOutput("rst_ram_we", 32'(ram_WE), 32'd0);
    checkOutput("rst_ram_rdy", 32'(ram_RDY), 32'd0);
    checkOutput("rst_ram_ab", 32'(ram_AB), 32'h000100);
    checkOutput("rst_rvalid", 32'(dma_rvalid), 32'd0);
    checkOutput("rst_err", 32'(dma_err), 32'd0);

    $display("[TB] CPU only");
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00);
    checkOutput("cpu_rdy", 32'(cpu_RDY), 32'd1);
    checkOutput("cpu_ram_ab", 32'(ram_AB), 32'h000100);
    checkOutput("cpu_ram_rdy", 32'(ram_RDY), 32'd1);
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00);
    checkOutput("cpu_di", 32'(cpu_DI), 32'h5A);
    checkOutput("cpu_no_ack", 32'(dma_ack), 32'd0);

    $display("[TB] forced grant");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000200, 8'h00);
      checkOutput("grant_wait_ack", 32'(dma_ack), 32'd0);
      checkOutput("grant_wait_rdy", 32'(cpu_RDY), 32'd1);
    end
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000200, 8'h00);
    checkOutput("grant_ack", 32'(dma_ack), 32'd1);
    checkOutput("grant_rdy_low", 32'(cpu_RDY), 32'd0);
    checkOutput("grant_ram_ab", 32'(ram_AB), 32'h000200);
    checkOutput("grant_ram_we", 32'(ram_WE), 32'd0);
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b0, 1'b0, 24'h000200, 8'h00);
    checkOutput("grant_rvalid", 32'(dma_rvalid), 32'd1);
    checkOutput("grant_rdata", 32'(dma_rdata), 32'hA5);
    checkOutput("grant_cpu_di_held", 32'(cpu_DI), 32'h5A);
    checkOutput("grant_fall_rdy", 32'(cpu_RDY), 32'd1);
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00);
    checkOutput("grant_rvalid_pulse", 32'(dma_rvalid), 32'd0);
    checkOutput("grant_cpu_di_after", 32'(cpu_DI), 32'h5A);

    $display("[TB] burst");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b1, 24'h000300, 8'h11);
      checkOutput("burst_wait_ack", 32'(dma_ack), 32'd0);
    end
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b1, 24'h000300, 8'h11);
    checkOutput("burst_ack1", 32'(dma_ack), 32'd1);
    checkOutput("burst_we1", 32'(ram_WE), 32'd1);
    checkOutput("burst_do1", 32'(ram_DO), 32'h11);
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b1, 24'h000301, 8'h22);
    checkOutput("burst_ack2", 32'(dma_ack), 32'd1);
    checkOutput("burst_ab2", 32'(ram_AB), 32'h000301);
    checkOutput("burst_no_rvalid", 32'(dma_rvalid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b1, 24'h000302, 8'h33);
      checkOutput("burst_cpu_share_ack", 32'(dma_ack), 32'd0);
      checkOutput("burst_cpu_share_rdy", 32'(cpu_RDY), 32'd1);
    end
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b1, 24'h000302, 8'h33);
    checkOutput("burst_ack3", 32'(dma_ack), 32'd1);
    checkOutput("burst_ab3", 32'(ram_AB), 32'h000302);
    applyStimulus(1'b1, 24'h000300, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00);
    applyStimulus(1'b1, 24'h000301, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00);
    checkOutput("burst_rb0", 32'(cpu_DI), 32'h11);
    applyStimulus(1'b1, 24'h000302, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00);
    checkOutput("burst_rb1", 32'(cpu_DI), 32'h22);
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00);
    checkOutput("burst_rb2", 32'(cpu_DI), 32'h33);

    $display("[TB] vector protect");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b1, 24'hFFFFF4, 8'hFF);
    end
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b1, 24'hFFFFF4, 8'hFF);
    checkOutput("vec_ack", 32'(dma_ack), 32'd1);
    checkOutput("vec_we_blocked", 32'(ram_WE), 32'd0);
    checkOutput("vec_ab", 32'(ram_AB), 32'hFFFFF4);
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00);
    checkOutput("vec_err", 32'(dma_err), 32'd1);
    checkOutput("vec_no_rvalid", 32'(dma_rvalid), 32'd0);
    applyStimulus(1'b1, 24'hFFFFF4, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00);
    checkOutput("vec_err_sticky", 32'(dma_err), 32'd1);
    applyStimulus(1'b1, 24'hFFFFF4, 1'b1, 8'h99, 1'b0, 1'b0, 24'h0, 8'h00);
    checkOutput("vec_readback", 32'(cpu_DI), 32'hC3);
    checkOutput("vec_cpu_we_pass", 32'(ram_WE), 32'd1);
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00);
    checkOutput("vec_readback2", 32'(cpu_DI), 32'hC3);

    $display("[TB] drop mid-burst");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000200, 8'h00);
    end
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000200, 8'h00);
    checkOutput("drop_ack", 32'(dma_ack), 32'd1);
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b0, 1'b0, 24'h000200, 8'h00);
    checkOutput("drop_rdy", 32'(cpu_RDY), 32'd1);
    checkOutput("drop_no_ack", 32'(dma_ack), 32'd0);
    checkOutput("drop_ram_ab", 32'(ram_AB), 32'h000100);
    checkOutput("drop_rvalid", 32'(dma_rvalid), 32'd1);
    checkOutput("drop_rdata", 32'(dma_rdata), 32'hA5);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000200, 8'h00);
      checkOutput("drop_cpu_state_ack", 32'(dma_ack), 32'd0);
    end
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000200, 8'h00);
    checkOutput("drop_regrant_ack", 32'(dma_ack), 32'd1);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000200, 8'h00);
    checkOutput("mrst_rvalid_before", 32'(dma_rvalid), 32'd1);
    checkOutput("mrst_rdy_forced", 32'(cpu_RDY), 32'd0);
    checkOutput("mrst_ack_forced", 32'(dma_ack), 32'd0);
    checkOutput("mrst_ram_rdy", 32'(ram_RDY), 32'd0);
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000200, 8'h00);
    checkOutput("mrst_rvalid_dropped", 32'(dma_rvalid), 32'd0);
    checkOutput("mrst_err_cleared", 32'(dma_err), 32'd0);
    checkOutput("mrst_cpu_state", 32'(cpu_RDY), 32'd1);
    checkOutput("mrst_wait_ack", 32'(dma_ack), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000200, 8'h00);
      checkOutput("mrst_wait_ack", 32'(dma_ack), 32'd0);
    end
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000200, 8'h00);
    checkOutput("mrst_regrant_ack", 32'(dma_ack), 32'd1);
    applyStimulus(1'b1, 24'h000100, 1'b0, 8'h00, 1'b0, 1'b0, 24'h0, 8'h00);
    checkOutput("mrst_rvalid_after", 32'(dma_rvalid), 32'd1);
    checkOutput("mrst_rdata_after", 32'(dma_rdata), 32'hA5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port synchronous system RAM (24-bit address, 8-bit data, 1-cycle registered read, read-only vector window at $FFFFF0–$FFFFFF) between the 65C2402 CPU and one DMA requester (loader or memory-dump engine). The CPU owns the RAM by default. A pending DMA request is granted after a bounded wait by stalling the CPU through RDY. The block sits between the CPU/DMA ports and the `ram` instance.

## Interface
- WAIT_MAX, 4: cycles a DMA request waits in CPU state before being forced in (legal range 1–255).
- BURST_MAX, 8: maximum consecutive DMA slots per grant window (legal range 1–255).
- clk  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  reset, synchronous, active-low
- cpu_AB  in  24  CPU address
- cpu_DO  in  8  CPU write data
- cpu_WE  in  1  CPU write enable
- cpu_DI  out  8  read data to CPU
- cpu_RDY  out  1  CPU ready; low stalls the CPU (CPU holds AB/DO/WE)
- dma_req  in  1  DMA request; held with addr/we/wdata stable until acked
- dma_we  in  1  DMA write (1) / read (0)
- dma_addr  in  24  DMA address
- dma_wdata  in  8  DMA write data
- dma_ack  out  1  slot issued this cycle for the presented request
- dma_rdata  out  8  DMA read data
- dma_rvalid  out  1  dma_rdata valid; one-cycle pulse
- dma_err  out  1  sticky: a DMA write targeted $FFFFF0–$FFFFFF
- ram_AB  out  24  to RAM AB
- ram_DO  out  8  to RAM DO
- ram_WE  out  1  to RAM WE
- ram_RDY  out  1  to RAM RDY
- ram_DI  in  8  from RAM DI

## Operation
- Registered state: CPU or DMA. Counters: wait_cnt (8 bit) and burst_cnt (8 bit). Registers: prev_owner, cpu_di_hold.
- **CPU state:**
  - RAM bus = CPU port; cpu_RDY=1; dma_ack=0.
  - If dma_req: wait_cnt++. When wait_cnt==WAIT_MAX-1, next state is DMA, and wait_cnt and burst_cnt are cleared.
  - If !dma_req: wait_cnt is cleared.
- **DMA state, dma_req=1:**
  - RAM bus = DMA port; cpu_RDY=0; dma_ack=1; burst_cnt++.
  - If burst_cnt==BURST_MAX-1, next state is CPU.
- **DMA state, dma_req=0:** fall-through. RAM bus = CPU; cpu_RDY=1; dma_ack=0; next state is CPU.
- **Write handling:**
  - ram_WE = owner WE.
  - A DMA write with dma_addr≥$FFFFF0 is still acked, but ram_WE is forced 0 and dma_err is set.
  - CPU writes to the vector window pass through unchanged; the RAM ignores them.
- **Read return:**
  - prev_owner records the owner of the previous cycle.
  - If prev_owner=CPU: cpu_DI=ram_DI, and cpu_di_hold<=ram_DI.
  - If prev_owner=DMA: cpu_DI=cpu_di_hold, so the stalled CPU never sees DMA data.
  - dma_rvalid=1 the cycle after a DMA read ack, with dma_rdata=ram_DI. It is 0 after DMA writes.
- ram_RDY=1 whenever reset_n=1.
- DMA owns every slot of a burst, so burst writes and reads may interleave freely.

## Timing
- **Reset:** while reset_n=0 at the clock edge, the following are applied on that edge:
  - state=CPU; wait_cnt=0; burst_cnt=0; prev_owner=CPU; cpu_di_hold=0.
  - dma_rvalid=0 (a pending read return is dropped); dma_err=0.
- **Outputs during reset:** cpu_RDY=0, dma_ack=0, ram_WE=0, ram_RDY=0. These are forced while reset_n=0. The RAM bus mirrors the CPU port.
- **Grant latency:** dma_req rising in CPU state at cycle 0 gives the first ack at cycle WAIT_MAX (WAIT_MAX=1: ack at cycle 1).
- **Burst length:** a burst lasts at most BURST_MAX acks, followed by at least WAIT_MAX CPU cycles before the next burst. This is the guaranteed CPU share.
- **Combinational outputs:** cpu_RDY, dma_ack, the ram_* mux, and cpu_DI depend combinationally on the registered state and dma_req. Everything else is registered.
- **Request dropped mid-burst:** fall-through that cycle, with CPU state from the next cycle.
- **Simultaneous events:** a new dma_req in the same cycle as the burst end starts wait_cnt at 0 in the following CPU cycle.

## Test plan
- **CPU only:** dma_req=0; CPU reads $000100 holding $5A → cpu_RDY stays 1 and cpu_DI=$5A one cycle after the address; no ack.
- **Forced grant, WAIT_MAX=4:**
  - Stimulus: dma_req read $000200 (holding $A5) asserted at cycle 0.
  - Required: dma_ack at cycle 4; cpu_RDY=0 at cycle 4; dma_rvalid with $A5 at cycle 5.
  - Required: cpu_DI at cycle 5 equals the last CPU read value, not $A5.
- **Burst, BURST_MAX=2:**
  - Stimulus: dma_req held continuously for writes of $11,$22,$33 to $000300–$000302.
  - Required: acks in 2 consecutive cycles, then 4 CPU cycles, then the third ack.
  - Required: RAM readback gives $11,$22,$33.
- **Vector protect:** DMA write $FF to $FFFFF4 → acked, ram_WE=0, dma_err=1 and sticky; a subsequent read of $FFFFF4 returns the original vector byte.
- **Drop mid-burst:** dma_req deasserted in the second DMA cycle → cpu_RDY=1 in that cycle; state=CPU next cycle.
- **Reset mid-operation:** reset_n=0 for one edge on the cycle after a DMA read ack → dma_rvalid=0, state=CPU, dma_err cleared; the next grant again takes WAIT_MAX cycles.
